header_insertion_arbiter: RTL and testbench
===========================================

// Module: header_insertion_arbiter
// PURPOSE
// Packet-level round-robin arbiter that shares one header_insertion datapath among
// NUM_SOURCES AXI-Stream packet sources (e.g. ARP, ICMP, UDP transmit paths).
// Each source presents its own header vector. The winner's header is latched for the
// whole packet, and the winner's stream is passed through to the shared inserter.
// The grant is held from the first beat to the accepted tlast, so packets never interleave.
// PARAMETERS
// NUM_SOURCES    4    number of requesting streams, 2..8
// BITS_PER_BEAT  512  AXI-Stream tdata width, multiple of 8
// HEADER_SIZE    112  header vector width per source, multiple of 8
// PORTS
// clock        in   1                          system clock
// reset        in   1                          synchronous, active-high
// s_tvalid     in   NUM_SOURCES                per-source tvalid
// s_tdata      in   NUM_SOURCES*BITS_PER_BEAT  source i at [i*BITS_PER_BEAT +: BITS_PER_BEAT]
// s_tlast      in   NUM_SOURCES                per-source tlast
// s_tkeep      in   NUM_SOURCES*BITS_PER_BEAT/8  source i at [i*BYTES +: BYTES]
// s_header     in   NUM_SOURCES*HEADER_SIZE    source i header; sampled only at grant
// s_tready     out  NUM_SOURCES                per-source tready
// m_tvalid     out  1                          to inserter tvalid_in
// m_tdata      out  BITS_PER_BEAT              to inserter tdata_in
// m_tlast      out  1                          to inserter tlast_in
// m_tkeep      out  BITS_PER_BEAT/8            to inserter tkeep_in
// m_tready     in   1                          from inserter tready_out
// m_header     out  HEADER_SIZE                to inserter header_data; registered
// grant        out  NUM_SOURCES                one-hot current owner, 0 when idle
// busy         out  1                          high while a packet owns the datapath
// BEHAVIOUR
// Reset (clock, reset: synchronous, active-high):
//  - grant=0, busy=0, m_header=0, round-robin pointer=0, state=IDLE.
//  - This makes m_tvalid=0, s_tready=0, m_tdata/m_tkeep=0 and m_tlast=0.
//  - Reset mid-packet abandons the packet; no tlast is synthesised.
// States:
//  - IDLE: grant=0. If any s_tvalid, select the first asserted index scanning
//    ptr, ptr+1, ... mod NUM_SOURCES.
//    Next edge: grant<=onehot(winner), m_header<=s_header[winner], busy<=1, go STREAM.
//    With no request, stay in IDLE.
//  - STREAM: pure combinational passthrough of the winner.
//    m_tvalid/m_tdata/m_tlast/m_tkeep come from source g; s_tready[g]=m_tready.
//    All other s_tready=0. m_tdata/m_tkeep/m_tlast are 0 when grant=0.
//    On m_tvalid&m_tready&m_tlast: next edge grant<=0, busy<=0, ptr<=(g+1) mod N, go IDLE.
//  - Unused state encodings go to IDLE.
// Latency and ordering:
//  - There is 1 cycle of arbitration latency. A request seen in cycle n gets grant
//    at edge n+1, and its first beat may transfer in cycle n+1.
//  - There is a mandatory one-cycle IDLE gap between packets. The inserter needs it to
//    return to WAIT_FOR_DATA.
// Handshake rules:
//  - m_header is stable from grant until the cycle after the last beat.
//  - Sources must keep tvalid asserted once raised until the beat is accepted.
//  - A requester that drops tvalid while ungranted simply loses that arbitration round.
//  - A granted source may stall (tvalid=0) indefinitely; grant is held and there is no timeout.
//  - Single-beat packets (tlast on the first beat) release after 1 beat.
// Simultaneous events:
//  - A new request arriving in the same cycle as a tlast is not granted before the IDLE cycle.
//  - The pointer update uses the finishing owner, not the newest requester.
// TESTING
// 1. Reset then single request: s_tvalid=0001, 3-beat packet, m_tready=1.
//    -> grant=0001 one cycle later; 3 beats pass through; m_header=s_header[0];
//       grant=0000 after tlast; ptr=1.
// 2. Fairness: all 4 sources request continuously, 2-beat packets each.
//    -> grant order 0001,0010,0100,1000,0001, with one IDLE cycle between packets.
// 3. Backpressure: granted source 2, m_tready toggles 1,0,0,1 during a 4-beat packet.
//    -> s_tready[2] mirrors m_tready; other s_tready stay 0;
//       no beat is duplicated or lost; grant is held throughout.
// 4. Header stability: change s_header[1] every cycle while source 1 streams 5 beats.
//    -> m_header holds the value sampled at grant for all 5 beats.
// 5. Reset mid-packet: assert reset on beat 2 of 4 from source 3.
//    -> next cycle grant=0, busy=0, m_tvalid=0, ptr=0;
//       next request from source 0 is granted first.
// 6. End-to-end: chain into header_insertion with 112-bit headers.
//    -> each output packet starts with its own source's header;
//       no interleaving across sources.

Source files
------------

// File: rtl/header_insertion_arbiter.sv
// Packet-level round-robin arbiter feeding one shared header inserter; 1-cycle grant latency, one IDLE gap between packets.
// Zero-latency passthrough of the owner's stream; s_tready of the owner mirrors m_tready, all others held low.
module header_insertion_arbiter #(
  parameter int NUM_SOURCES   = 4,
  parameter int BITS_PER_BEAT = 512,
  parameter int HEADER_SIZE   = 112
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic [NUM_SOURCES-1:0]                   s_tvalid,
  input  logic [NUM_SOURCES*BITS_PER_BEAT-1:0]     s_tdata,
  input  logic [NUM_SOURCES-1:0]                   s_tlast,
  input  logic [NUM_SOURCES*(BITS_PER_BEAT/8)-1:0] s_tkeep,
  input  logic [NUM_SOURCES*HEADER_SIZE-1:0]       s_header,
  output logic [NUM_SOURCES-1:0]                   s_tready,
  output logic                                     m_tvalid,
  output logic [BITS_PER_BEAT-1:0]                 m_tdata,
  output logic                                     m_tlast,
  output logic [BITS_PER_BEAT/8-1:0]               m_tkeep,
  input  logic                                     m_tready,
  output logic [HEADER_SIZE-1:0]                   m_header,
  output logic [NUM_SOURCES-1:0]                   grant,
  output logic                                     busy
);

  localparam int BYTES = BITS_PER_BEAT / 8;
  localparam int IDX_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam logic [IDX_W:0] NS_W = (IDX_W+1)'(NUM_SOURCES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1
  } state_t;

  state_t                   r_state;
  logic [NUM_SOURCES-1:0]   r_grant;
  logic                     r_busy;
  logic [HEADER_SIZE-1:0]   r_header;
  logic [IDX_W-1:0]         r_ptr;
  logic [IDX_W-1:0]         r_owner;

  logic                     w_req_found;
  logic [IDX_W-1:0]         w_winner;
  logic [IDX_W:0]           w_scan_idx;
  logic [NUM_SOURCES-1:0]   w_winner_onehot;
  logic [HEADER_SIZE-1:0]   w_winner_header;
  logic                     w_tvalid;
  logic                     w_tlast;
  logic [BITS_PER_BEAT-1:0] w_tdata;
  logic [BYTES-1:0]         w_tkeep;
  logic [NUM_SOURCES-1:0]   w_tready;
  logic                     w_last_xfer;
  logic [IDX_W-1:0]         w_ptr_next;

  // Scan requesters starting at the round-robin pointer, wrapping modulo NUM_SOURCES.
  always_comb begin
    w_req_found = 1'b0;
    w_winner    = '0;
    w_scan_idx  = '0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      w_scan_idx = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_scan_idx >= NS_W)
        w_scan_idx = w_scan_idx - NS_W;
      if (!w_req_found && s_tvalid[w_scan_idx[IDX_W-1:0]]) begin
        w_req_found = 1'b1;
        w_winner    = w_scan_idx[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    w_winner_onehot = '0;
    w_winner_header = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (w_winner == IDX_W'(i)) begin
        w_winner_onehot[i] = 1'b1;
        w_winner_header    = s_header[i*HEADER_SIZE +: HEADER_SIZE];
      end
    end
  end

  // AND-OR mux on the registered one-hot grant; everything reads 0 while idle.
  always_comb begin
    w_tvalid = 1'b0;
    w_tlast  = 1'b0;
    w_tdata  = '0;
    w_tkeep  = '0;
    w_tready = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (r_grant[i]) begin
        w_tvalid    = w_tvalid | s_tvalid[i];
        w_tlast     = w_tlast  | s_tlast[i];
        w_tdata     = w_tdata  | s_tdata[i*BITS_PER_BEAT +: BITS_PER_BEAT];
        w_tkeep     = w_tkeep  | s_tkeep[i*BYTES +: BYTES];
        w_tready[i] = m_tready;
      end
    end
  end

  assign w_last_xfer = w_tvalid & m_tready & w_tlast;
  assign w_ptr_next  = (r_owner == IDX_W'(NUM_SOURCES-1)) ? '0 : r_owner + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_busy   <= 1'b0;
      r_header <= '0;
      r_ptr    <= '0;
      r_owner  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_found) begin
            r_grant  <= w_winner_onehot;
            r_owner  <= w_winner;
            r_header <= w_winner_header;
            r_busy   <= 1'b1;
            r_state  <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          // Header is left in place after release so it stays stable past the last beat.
          if (w_last_xfer) begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= w_ptr_next;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_tready = w_tready;
  assign m_tvalid = w_tvalid;
  assign m_tdata  = w_tdata;
  assign m_tlast  = w_tlast;
  assign m_tkeep  = w_tkeep;
  assign m_header = r_header;
  assign grant    = r_grant;
  assign busy     = r_busy;

endmodule

// File: tb/tb_header_insertion_arbiter.sv
// Randomized bench for header_insertion_arbiter: per-source packet drivers feed a scoreboard,
// and a negedge monitor checks grant order, header capture, handshakes and beat contents.
`timescale 1ns/1ps
module tb_header_insertion_arbiter;

  localparam int NS    = 4;
  localparam int BPB   = 512;
  localparam int HS    = 112;
  localparam int BY    = BPB / 8;
  localparam int N_GEN = 3000;
  localparam int N_DRN = 300;

  typedef struct {
    logic [BPB-1:0] data;
    logic [BY-1:0]  keep;
    logic           last;
  } beat_t;

  logic             clock = 1'b0;
  logic             reset;
  logic [NS-1:0]    s_tvalid;
  logic [NS*BPB-1:0] s_tdata;
  logic [NS-1:0]    s_tlast;
  logic [NS*BY-1:0] s_tkeep;
  logic [NS*HS-1:0] s_header;
  logic [NS-1:0]    s_tready;
  logic             m_tvalid;
  logic [BPB-1:0]   m_tdata;
  logic             m_tlast;
  logic [BY-1:0]    m_tkeep;
  logic             m_tready;
  logic [HS-1:0]    m_header;
  logic [NS-1:0]    grant;
  logic             busy;

  header_insertion_arbiter #(
    .NUM_SOURCES(NS), .BITS_PER_BEAT(BPB), .HEADER_SIZE(HS)
  ) dut (
    .clock(clock), .reset(reset),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tkeep(s_tkeep),
    .s_header(s_header), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tkeep(m_tkeep),
    .m_tready(m_tready), .m_header(m_header), .grant(grant), .busy(busy)
  );

  always #5 clock = ~clock;

  beat_t exp_q [NS][$];
  beat_t drv_q [NS][$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  task automatic chk(input string name, input logic [BPB-1:0] act, input logic [BPB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [BPB-1:0] rand_wide();
    logic [BPB-1:0] r;
    for (int w = 0; w < BPB/32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference model: owner of the datapath (-1 = idle), pointer and header latched at grant.
  int            md_owner = -1;
  int            md_ptr   = 0;
  logic [HS-1:0] md_hdr   = '0;
  int            md_idx;
  logic [NS-1:0] exp_grant;
  logic [NS-1:0] exp_rdy;
  beat_t         eb;

  always @(negedge clock) begin
    if (reset) begin
      md_owner = -1;
      md_ptr   = 0;
      md_hdr   = '0;
    end else begin
      exp_grant = (md_owner >= 0) ? (NS'(1) << md_owner) : '0;
      exp_rdy   = m_tready ? exp_grant : '0;
      chk("grant",    BPB'(grant),    BPB'(exp_grant));
      chk("busy",     BPB'(busy),     BPB'(md_owner >= 0));
      chk("m_header", BPB'(m_header), BPB'(md_hdr));
      chk("s_tready", BPB'(s_tready), BPB'(exp_rdy));
      if (md_owner < 0) begin
        chk("idle_m_tvalid", BPB'(m_tvalid), '0);
        chk("idle_m_tlast",  BPB'(m_tlast),  '0);
        chk("idle_m_tkeep",  BPB'(m_tkeep),  '0);
        chk("idle_m_tdata",  m_tdata,        '0);
        for (int k = 0; k < NS; k++) begin
          md_idx = (md_ptr + k) % NS;
          if (s_tvalid[md_idx]) begin
            md_owner = md_idx;
            md_hdr   = s_header[md_idx*HS +: HS];
            break;
          end
        end
      end else begin
        chk("m_tvalid", BPB'(m_tvalid), BPB'(s_tvalid[md_owner]));
        if (s_tvalid[md_owner] && m_tready) begin
          if (exp_q[md_owner].size() == 0) begin
            chk("beat_expected", BPB'(1), BPB'(0));
          end else begin
            eb = exp_q[md_owner].pop_front();
            chk("m_tdata", m_tdata,        eb.data);
            chk("m_tkeep", BPB'(m_tkeep),  BPB'(eb.keep));
            chk("m_tlast", BPB'(m_tlast),  BPB'(eb.last));
            if (eb.last) begin
              md_ptr   = (md_owner + 1) % NS;
              md_owner = -1;
            end
          end
        end
      end
    end
  end

  logic [NS-1:0] acc;
  logic          bsy;
  bit            gen_en;
  bit            rst_done;
  int            plen;
  beat_t         nb;

  initial begin
    reset    = 1'b1;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tlast  = '0;
    s_tkeep  = '0;
    s_header = '0;
    m_tready = 1'b0;
    gen_en   = 1'b1;
    rst_done = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    for (int cyc = 0; cyc < N_GEN + N_DRN; cyc++) begin
      @(negedge clock);
      acc = s_tvalid & s_tready;
      bsy = busy;
      @(posedge clock);
      #1;
      reset  = 1'b0;
      gen_en = (cyc < N_GEN);

      if (!rst_done && cyc > N_GEN/2 && bsy) begin
        // Abandon whatever is in flight; nothing of it must appear afterwards.
        rst_done = 1'b1;
        reset    = 1'b1;
        s_tvalid = '0;
        for (int i = 0; i < NS; i++) begin
          exp_q[i].delete();
          drv_q[i].delete();
        end
        continue;
      end

      for (int i = 0; i < NS; i++) begin
        if (acc[i] && drv_q[i].size() != 0) begin
          void'(drv_q[i].pop_front());
          s_tvalid[i] = 1'b0;
        end
        if (!s_tvalid[i]) begin
          if (drv_q[i].size() == 0 && gen_en && $urandom_range(0, 3) == 0) begin
            plen = $urandom_range(1, 5);
            for (int j = 0; j < plen; j++) begin
              nb.data = rand_wide();
              nb.last = (j == plen - 1);
              nb.keep = nb.last ? (BY'(1) | BY'(rand_wide())) : '1;
              exp_q[i].push_back(nb);
              drv_q[i].push_back(nb);
            end
          end
          if (drv_q[i].size() != 0 && $urandom_range(0, 3) != 0) begin
            s_tvalid[i]              = 1'b1;
            s_tdata[i*BPB +: BPB]    = drv_q[i][0].data;
            s_tkeep[i*BY +: BY]      = drv_q[i][0].keep;
            s_tlast[i]               = drv_q[i][0].last;
          end else begin
            s_tdata[i*BPB +: BPB]    = rand_wide();
            s_tkeep[i*BY +: BY]      = BY'(rand_wide());
            s_tlast[i]               = 1'($urandom);
          end
        end
        s_header[i*HS +: HS] = HS'(rand_wide());
      end
      m_tready = gen_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    @(negedge clock);
    for (int i = 0; i < NS; i++)
      chk("residual_beats", BPB'(exp_q[i].size()), '0);
    chk("reset_exercised", BPB'(rst_done), BPB'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
